// File: rtl/probe_sig_gen_if.sv
// probe_sig_gen_if: beep pattern request/busy/done handshake.
// master = test controller, slave = probe_sig_gen.
interface probe_sig_gen_if;
   logic beep_req;
   logic beep_type;
   logic beep_busy;
   logic beep_done;

   modport master (
      output beep_req,
      output beep_type,
      input  beep_busy,
      input  beep_done
   );

   modport slave (
      input  beep_req,
      input  beep_type,
      output beep_busy,
      output beep_done
   );
endinterface

// File: rtl/probe_sig_gen.sv
// probe_sig_gen: decade probe taps, glitch-free probe mux, pass/fail beeper.
// PROBE_SIG_LEGACY_EN adds passfail_spk_sel (continuous speaker tone override).
module probe_sig_gen #(
   parameter int CLK_HZ        = 100_000_000,
   parameter int NUM_TAPS      = 4,
   parameter int BASE_HZ       = 10,
   parameter int SEL_W         = 2,
   parameter int SPK_TONE_SEL  = 2,
   parameter int BEEP_LONG_MS  = 500,
   parameter int BEEP_SHORT_MS = 100,
   parameter int GAP_MS        = 100,
   parameter int FAIL_BEEPS    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEL_W-1:0] probe_sel,
   output logic             probe_out,
`ifdef PROBE_SIG_LEGACY_EN
   input  logic             passfail_spk_sel,
`endif
   output logic             passfail_spk,
   probe_sig_gen_if.slave   beep
);

   function automatic longint pow10(input int k);
      longint p;
      p = 1;
      for (int i = 0; i < k; i++) p = p * 10;
      return p;
   endfunction

   localparam int NSEL = 2 ** SEL_W;
   localparam longint HALF0 =
      longint'(CLK_HZ) / (2 * longint'(BASE_HZ));
   localparam int CW = $clog2(HALF0) + 1;
   localparam int MS_CYC = CLK_HZ / 1000;
   localparam int MW = $clog2(MS_CYC) + 1;
   localparam int DMAX0 =
      (BEEP_LONG_MS > BEEP_SHORT_MS) ? BEEP_LONG_MS : BEEP_SHORT_MS;
   localparam int DMAX = (DMAX0 > GAP_MS) ? DMAX0 : GAP_MS;
   localparam int DW = $clog2(DMAX + 1);
   localparam logic [SEL_W-1:0] SPK_IDX = SEL_W'(SPK_TONE_SEL);

   if (NUM_TAPS < 1 || NUM_TAPS > 8 || NSEL < NUM_TAPS ||
       SPK_TONE_SEL >= NUM_TAPS || FAIL_BEEPS < 1 ||
       FAIL_BEEPS > 15 || MS_CYC < 1) begin : g_bad_cfg
      $error("probe_sig_gen: bad parameter set");
   end

   logic [NSEL-1:0] tap_ext;

   for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
      localparam longint DIV = 2 * longint'(BASE_HZ) * pow10(k);
      localparam longint HALF = longint'(CLK_HZ) / DIV;
      localparam logic [CW-1:0] LIM = CW'(HALF - 1);
      logic [CW-1:0] cnt;
      logic          t;

      if (HALF < 1 || (longint'(CLK_HZ) % DIV) != 0) begin : g_bad
         $error("probe_sig_gen: tap %0d half period invalid", k);
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt <= '0;
            t   <= 1'b0;
         end else if (cnt == LIM) begin
            cnt <= '0;
            t   <= ~t;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end

      assign tap_ext[k] = t;
   end

   for (genvar k = NUM_TAPS; k < NSEL; k++) begin : g_pad
      assign tap_ext[k] = 1'b0;
   end

   logic [SEL_W-1:0] sel_m, sel_s, sel_a;

   // Switch only while both old and new sources are low: no runt highs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_m     <= '0;
         sel_s     <= '0;
         sel_a     <= '0;
         probe_out <= 1'b0;
      end else begin
         sel_m <= probe_sel;
         sel_s <= sel_m;
         if (sel_s != sel_a && !probe_out && !tap_ext[sel_s])
            sel_a <= sel_s;
         probe_out <= tap_ext[sel_a];
      end
   end

   logic [MW-1:0] ms_cnt;
   logic          ms_tick;

   assign ms_tick = (ms_cnt == MW'(MS_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ms_cnt <= '0;
      else if (ms_tick) ms_cnt <= '0;
      else ms_cnt <= ms_cnt + MW'(1);
   end

   typedef enum logic [1:0] {
      IDLE, TONE, GAP, DONE
   } state_t;

   state_t        state, state_n;
   logic [DW-1:0] dur, dur_n, tone_last;
   logic [3:0]    nbeep, nbeep_n;
   logic          fail, fail_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         dur   <= '0;
         nbeep <= '0;
         fail  <= 1'b0;
      end else begin
         state <= state_n;
         dur   <= dur_n;
         nbeep <= nbeep_n;
         fail  <= fail_n;
      end
   end

   assign tone_last = fail ? DW'(BEEP_SHORT_MS - 1)
                           : DW'(BEEP_LONG_MS - 1);

   always_comb begin
      state_n = state;
      dur_n   = dur;
      nbeep_n = nbeep;
      fail_n  = fail;
      unique case (state)
         IDLE: begin
            if (beep.beep_req) begin
               state_n = TONE;
               fail_n  = beep.beep_type;
               dur_n   = '0;
               nbeep_n = '0;
            end
         end
         TONE: begin
            if (ms_tick) begin
               if (dur == tone_last) begin
                  dur_n = '0;
                  if (!fail || nbeep == 4'(FAIL_BEEPS - 1)) begin
                     state_n = DONE;
                  end else begin
                     state_n = GAP;
                     nbeep_n = nbeep + 4'd1;
                  end
               end else begin
                  dur_n = dur + DW'(1);
               end
            end
         end
         GAP: begin
            if (ms_tick) begin
               if (dur == DW'(GAP_MS - 1)) begin
                  state_n = TONE;
                  dur_n   = '0;
               end else begin
                  dur_n = dur + DW'(1);
               end
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign beep.beep_busy = (state != IDLE);
   assign beep.beep_done = (state == DONE);

   logic spk_on;

`ifdef PROBE_SIG_LEGACY_EN
   logic lsel_m, lsel_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lsel_m <= 1'b0;
         lsel_s <= 1'b0;
      end else begin
         lsel_m <= passfail_spk_sel;
         lsel_s <= lsel_m;
      end
   end

   assign spk_on = (state == TONE) | lsel_s;
`else
   assign spk_on = (state == TONE);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) passfail_spk <= 1'b0;
      else passfail_spk <= spk_on & tap_ext[SPK_IDX];
   end

endmodule

// File: tb/tb_probe_sig_gen.sv
// tb_probe_sig_gen: directed checks of probe taps, probe mux and beeper.
// Small clock (20 kHz) so 1 ms = 20 cycles and taps have 1000/100/10 halves.
module tb_probe_sig_gen;

   logic       clk;
   logic       rst;
   logic [1:0] probe_sel;
   logic       probe_out;
   logic       spk;
`ifdef PROBE_SIG_LEGACY_EN
   logic       spk_sel;
`endif

   probe_sig_gen_if bif ();

   probe_sig_gen #(
      .CLK_HZ       (20_000),
      .NUM_TAPS     (3),
      .BASE_HZ      (10),
      .SEL_W        (2),
      .SPK_TONE_SEL (2),
      .BEEP_LONG_MS (500),
      .BEEP_SHORT_MS(100),
      .GAP_MS       (100),
      .FAIL_BEEPS   (3)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .probe_sel       (probe_sel),
      .probe_out       (probe_out),
`ifdef PROBE_SIG_LEGACY_EN
      .passfail_spk_sel(spk_sel),
`endif
      .passfail_spk    (spk),
      .beep            (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   ntests = 0;
   int   nfail  = 0;
   logic cur;

   typedef struct {
      logic [1:0] sel;
      int         half;
   } vec_t;

   vec_t vt[5];

   task automatic check(input string nm, input int act, input int exp);
      ntests++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic check_rng(input string nm, input int act,
                            input int lo, input int hi);
      ntests++;
      if (act < lo || act > hi) begin
         nfail++;
         $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cur = probe_out;
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_len(input logic lvl, input int maxn,
                          output int n);
      n = 0;
      while (cur == lvl && n < maxn) begin
         n++;
         step();
      end
   endtask

   task automatic start_beep(input logic typ);
      bif.beep_req  = 1'b1;
      bif.beep_type = typ;
      step();
      bif.beep_req  = 1'b0;
      bif.beep_type = 1'b0;
   endtask

   task automatic run_pattern(input int inj, output int nb,
                              output int nhi, output int nd,
                              output int ngap, output int gmin,
                              output int gmax, output int hmax);
      int lo_run;
      int hi_run;
      nb = 0; nhi = 0; nd = 0; ngap = 0;
      gmin = 1 << 30; gmax = 0; hmax = 0;
      lo_run = 0; hi_run = 0;
      for (int c = 0; c < 12000 && bif.beep_busy; c++) begin
         if (c == inj) begin
            bif.beep_req  = 1'b1;
            bif.beep_type = 1'b0;
         end
         if (c == inj + 1) bif.beep_req = 1'b0;
         nb++;
         if (bif.beep_done) nd++;
         if (spk) begin
            nhi++;
            hi_run++;
            if (hi_run > hmax) hmax = hi_run;
            if (lo_run > 50) begin
               ngap++;
               if (lo_run < gmin) gmin = lo_run;
               if (lo_run > gmax) gmax = lo_run;
            end
            lo_run = 0;
         end else begin
            lo_run++;
            hi_run = 0;
         end
         step();
      end
   endtask

   initial begin
      int n, hi, lo;
      int nb, nhi, nd, ngap, gmin, gmax, hmax;

      vt[0] = '{sel: 2'd2, half: 10};
      vt[1] = '{sel: 2'd1, half: 100};
      vt[2] = '{sel: 2'd3, half: 0};
      vt[3] = '{sel: 2'd1, half: 100};
      vt[4] = '{sel: 2'd0, half: 1000};

      rst = 1'b1;
      probe_sel = 2'd0;
      bif.beep_req = 1'b0;
      bif.beep_type = 1'b0;
`ifdef PROBE_SIG_LEGACY_EN
      spk_sel = 1'b0;
`endif
      step_n(3);
      check("rst probe_out", int'(probe_out), 0);
      check("rst spk", int'(spk), 0);
      check("rst busy", int'(bif.beep_busy), 0);
      check("rst done", int'(bif.beep_done), 0);

      @(posedge clk);
      #1 rst = 1'b0;
      step();
      run_len(1'b0, 2500, n);
      check("first low", n, 1001);
      run_len(1'b1, 2500, n);
      check("tap0 high", n, 1000);
      run_len(1'b0, 2500, n);
      check("tap0 low", n, 1000);

      for (int i = 0; i < 5; i++) begin
         probe_sel = vt[i].sel;
         step_n(2200);
         if (vt[i].half == 0) begin
            n = 0;
            for (int c = 0; c < 2100; c++) begin
               step();
               if (cur) n++;
            end
            check("sel3 highs", n, 0);
         end else begin
            run_len(cur, 2500, n);
            if (cur == 1'b0) run_len(1'b0, 2500, n);
            run_len(1'b1, 2500, hi);
            run_len(1'b0, 2500, lo);
            check($sformatf("sel%0d high", vt[i].sel), hi, vt[i].half);
            check($sformatf("sel%0d low", vt[i].sel), lo, vt[i].half);
         end
      end

      // Now at the first high sample of tap0; request tap1 mid-pulse.
      probe_sel = 2'd1;
      run_len(1'b1, 2500, n);
      check("defer high", n, 1000);
      run_len(1'b0, 2500, n);
      for (int p = 0; p < 3; p++) begin
         run_len(1'b1, 2500, hi);
         check($sformatf("post switch hi%0d", p), hi, 100);
         run_len(1'b0, 2500, lo);
      end

      start_beep(1'b0);
      check("pass busy", int'(bif.beep_busy), 1);
      run_pattern(-5, nb, nhi, nd, ngap, gmin, gmax, hmax);
      check_rng("pass busy len", nb, 9980, 10021);
      check_rng("pass spk highs", nhi, 4970, 5020);
      check("pass max hi run", hmax, 10);
      check("pass gaps", ngap, 0);
      check("pass done", nd, 1);
      check("pass busy after", int'(bif.beep_busy), 0);
      n = 0;
      for (int c = 0; c < 50; c++) begin
         if (bif.beep_busy || bif.beep_done) n++;
         step();
      end
      check("pass idle after", n, 0);

      start_beep(1'b1);
      check("fail busy", int'(bif.beep_busy), 1);
      run_pattern(3000, nb, nhi, nd, ngap, gmin, gmax, hmax);
      check_rng("fail busy len", nb, 9980, 10021);
      check_rng("fail spk highs", nhi, 2960, 3030);
      check("fail max hi run", hmax, 10);
      check("fail gaps", ngap, 2);
      check_rng("fail gap min", gmin, 1980, 2040);
      check_rng("fail gap max", gmax, 1980, 2040);
      check("fail done", nd, 1);
      n = 0;
      for (int c = 0; c < 50; c++) begin
         if (bif.beep_busy || bif.beep_done) n++;
         step();
      end
      check("fail idle after", n, 0);

      start_beep(1'b1);
      step_n(7000);
      check("gap2 busy", int'(bif.beep_busy), 1);
      check("gap2 spk", int'(spk), 0);
      #1 rst = 1'b1;
      #1;
      check("rst mid spk", int'(spk), 0);
      check("rst mid busy", int'(bif.beep_busy), 0);
      check("rst mid done", int'(bif.beep_done), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      nb = 0;
      nd = 0;
      for (int c = 0; c < 200; c++) begin
         step();
         if (bif.beep_busy) nb++;
         if (bif.beep_done) nd++;
      end
      check("post rst busy", nb, 0);
      check("post rst done", nd, 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
